ed25519_sig_packer: RTL

//  Downstream stage of the Ed25519 sign datapath. Captures R (encoded point, 256b) from the base-point

---
 rtl/ed25519_sig_pkg.sv | 17 +
 rtl/ed25519_lt_l.sv | 12 +
 rtl/ed25519_sig_packer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ed25519_sig_pkg.sv
// Shared definitions for the Ed25519 signature packer: FSM encoding, group order L and
// signature width.
package ed25519_sig_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StStream,
        StDone
    } sig_state_e;

    localparam int unsigned SIG_BITS = 512;

    localparam logic [255:0] ED25519_L =
        256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

endpackage

// File: rtl/ed25519_lt_l.sv
// Combinational comparator: oLt is high when the 256-bit value iX is below the group order L.
// The vector is the little-endian byte string read as an integer, so a plain compare suffices.
module ed25519_lt_l
    import ed25519_sig_pkg::*;
(
    input  logic [255:0] iX,
    output logic         oLt
);

    assign oLt = (iX < ED25519_L);

endmodule

// File: rtl/ed25519_sig_packer.sv
// Collects R and S in either order and streams {3'b0, S, R} as WORD_W-bit words, word 0 first.
// Define ED25519_SIG_CANON_CHECK_EN to flag non-canonical S (S >= L) on oSErr.
module ed25519_sig_packer
    import ed25519_sig_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClear,
    input  logic              iR_valid,
    input  logic [255:0]      iR,
    input  logic              iS_valid,
    input  logic [252:0]      iS,
    output logic              oBusy,
    output logic              oValid,
    input  logic              iReady,
    output logic [WORD_W-1:0] oWord,
    output logic              oLast,
    output logic              oDone,
    output logic              oOverrun,
    output logic              oSErr
);

    localparam int unsigned NUM_WORDS = SIG_BITS / WORD_W;
    localparam int unsigned CntW      = $clog2(NUM_WORDS);

    sig_state_e          state_q, state_d;
    logic [255:0]        r_q, r_d;
    logic [252:0]        s_q, s_d;
    logic                got_r_q, got_r_d;
    logic                got_s_q, got_s_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                last_q, last_d;
    logic                overrun_q, overrun_d;
    logic                strobe;

    logic [SIG_BITS-1:0]                sig_d;
    logic [NUM_WORDS-1:0][WORD_W-1:0]   words_d;

    assign strobe = iR_valid | iS_valid;

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        s_d       = s_q;
        got_r_d   = got_r_q;
        got_s_d   = got_s_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        if (iClear) begin
            state_d   = StIdle;
            got_r_d   = 1'b0;
            got_s_d   = 1'b0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (iR_valid) begin
                        r_d     = iR;
                        got_r_d = 1'b1;
                    end
                    if (iS_valid) begin
                        s_d     = iS;
                        got_s_d = 1'b1;
                    end
                    if (strobe) begin
                        cnt_d   = '0;
                        state_d = (iR_valid && iS_valid) ? StStream : StCollect;
                    end
                end
                StCollect: begin
                    // Repeated strobes overwrite: the latest operand is the one streamed.
                    if (iR_valid) begin
                        r_d     = iR;
                        got_r_d = 1'b1;
                    end
                    if (iS_valid) begin
                        s_d     = iS;
                        got_s_d = 1'b1;
                    end
                    if (got_r_d && got_s_d) begin
                        state_d = StStream;
                    end
                end
                StStream: begin
                    if (strobe) begin
                        overrun_d = 1'b1;
                    end
                    if (iReady) begin
                        if (cnt_q == CntW'(NUM_WORDS - 1)) begin
                            cnt_d   = '0;
                            state_d = StDone;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (strobe) begin
                        overrun_d = 1'b1;
                    end
                    got_r_d = 1'b0;
                    got_s_d = 1'b0;
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Output word is built from next-state operands so word 0 appears the cycle after the
    // completing strobe.
    assign sig_d   = {3'b000, s_d, r_d};
    assign words_d = sig_d;

    always_comb begin
        word_d = '0;
        last_d = 1'b0;
        if (state_d == StStream) begin
            word_d = words_d[cnt_d];
            last_d = (cnt_d == CntW'(NUM_WORDS - 1));
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= StIdle;
            r_q       <= '0;
            s_q       <= '0;
            got_r_q   <= 1'b0;
            got_s_q   <= 1'b0;
            cnt_q     <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            s_q       <= s_d;
            got_r_q   <= got_r_d;
            got_s_q   <= got_s_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    assign oBusy    = (state_q == StCollect) || (state_q == StStream);
    assign oValid   = (state_q == StStream);
    assign oDone    = (state_q == StDone);
    assign oWord    = word_q;
    assign oLast    = last_q;
    assign oOverrun = overrun_q;

`ifdef ED25519_SIG_CANON_CHECK_EN
    logic s_lt;
    logic serr_q, serr_d;

    ed25519_lt_l u_lt_l (
        .iX  ({3'b000, iS}),
        .oLt (s_lt)
    );

    // A new signature restarts the flag; further S captures in COLLECT accumulate.
    always_comb begin
        serr_d = serr_q;
        if (iClear) begin
            serr_d = 1'b0;
        end else if ((state_q == StIdle) && strobe) begin
            serr_d = iS_valid & ~s_lt;
        end else if ((state_q == StCollect) && iS_valid) begin
            serr_d = serr_q | ~s_lt;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            serr_q <= 1'b0;
        end else begin
            serr_q <= serr_d;
        end
    end

    assign oSErr = serr_q;
`else
    assign oSErr = 1'b0;
`endif

endmodule
